pulse_stretcher: RTL

//   Output-side counterpart of the push-button input path. Takes clean 1-cycle

---
 rtl/pulse_stretcher.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle event strobes into fixed ON pulses separated by a mandatory OFF gap.
// Optional event queue enabled by defining PULSE_STRETCHER_QUEUE_EN; otherwise busy-time events are dropped.
module pulse_stretcher #(
  parameter int                 CNT_W    = 16,
  parameter logic [CNT_W-1:0]   ON_LEN   = 16'hFFFF,
  parameter logic [CNT_W-1:0]   GAP_LEN  = 16'hFFFF,
  parameter int                 QDEPTH_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ev_in,
  output logic                led,
  output logic                busy,
  output logic [QDEPTH_W-1:0] pending,
  output logic                dropped
);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  localparam logic [QDEPTH_W-1:0] PEND_MAX = '1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [QDEPTH_W-1:0] pend_q, pend_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic                consume;
  logic                enq;
  logic [QDEPTH_W-1:0] pend_after;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    drop_d     = 1'b0;
    consume    = 1'b0;
    enq        = 1'b0;
    pend_after = pend_q;
    case (state_q)
      // A leftover queued event (queued on the final gap cycle) restarts from IDLE;
      // a fresh event in the same cycle replaces the one consumed.
      IDLE: begin
        if (ev_in || (pend_q != '0)) begin
          state_d = ON;
          cnt_d   = '0;
          consume = !ev_in;
        end
      end
      ON: begin
        enq = ev_in;
        if (cnt_q == ON_LEN - 1'b1) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        enq = ev_in;
        if (cnt_q == GAP_LEN - 1'b1) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            state_d = ON;
            consume = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef PULSE_STRETCHER_QUEUE_EN
    // Consume before enqueue so a saturated queue can still absorb an event on a replay cycle.
    pend_after = pend_q - {{(QDEPTH_W-1){1'b0}}, consume};
    if (enq && (pend_after == PEND_MAX)) begin
      drop_d = 1'b1;
      pend_d = pend_after;
    end else begin
      pend_d = pend_after + {{(QDEPTH_W-1){1'b0}}, enq};
    end
`else
    pend_after = '0;
    pend_d     = '0;
    drop_d     = enq;
`endif

    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign dropped = drop_q;

endmodule
